// File: rtl/instruction_decode_stage.sv
// MIPS32 decode stage: main control decoder, 32x32 register file with WB bypass,
// and the 16-to-32-bit immediate extender. The register file is the only state.
module instruction_decode_stage (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic [4:0]  rDestSelected,
    input  logic [31:0] regWriteData,
    input  logic        RegWrite,
    output logic        PCSel,
    output logic        RegDst,
    output logic        ALUSrc0,
    output logic [1:0]  ALUSrc1,
    output logic        R_Enable,
    output logic        W_Enable,
    output logic [1:0]  R_Width,
    output logic [1:0]  W_Width,
    output logic        MemToReg,
    output logic        RegWriteOut,
    output logic        BranchSel,
    output logic [31:0] Reg_Data1,
    output logic [31:0] Reg_Data2,
    output logic [31:0] Imm32b
);

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_SPEC2  = 6'h1C;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_MUL  = 6'h02;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;

    assign opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign imm    = Instruction[15:0];
    assign funct  = Instruction[5:0];

    // ---------------- register file ----------------
    logic [31:0] regs [32];
    logic        wr_active;

    assign wr_active = RegWrite && (rDestSelected != 5'd0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[rDestSelected] <= regWriteData;
        end
    end

    // WB bypass lets a value written this cycle be read in the same cycle.
    always_comb begin
        if (rs == 5'd0)
            Reg_Data1 = '0;
        else if (wr_active && rDestSelected == rs)
            Reg_Data1 = regWriteData;
        else
            Reg_Data1 = regs[rs];

        if (rt == 5'd0)
            Reg_Data2 = '0;
        else if (wr_active && rDestSelected == rt)
            Reg_Data2 = regWriteData;
        else
            Reg_Data2 = regs[rt];
    end

    // ---------------- immediate extender ----------------
    always_comb begin
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: Imm32b = {16'h0000, imm};
            default:                          Imm32b = {{16{imm[15]}}, imm};
        endcase
    end

    // ---------------- control decoder ----------------
    logic       d_pc_sel, d_reg_dst, d_alu_src0, d_r_en, d_w_en;
    logic       d_mem_to_reg, d_reg_write, d_branch;
    logic [1:0] d_alu_src1, d_r_width, d_w_width;

    always_comb begin
        d_pc_sel     = 1'b0;
        d_reg_dst    = 1'b0;
        d_alu_src0   = 1'b0;
        d_alu_src1   = 2'b00;
        d_r_en       = 1'b0;
        d_w_en       = 1'b0;
        d_r_width    = 2'b00;
        d_w_width    = 2'b00;
        d_mem_to_reg = 1'b0;
        d_reg_write  = 1'b0;
        d_branch     = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_XOR,
                    FN_SLT, FN_SLTU: begin
                        d_reg_dst   = 1'b1;
                        d_reg_write = 1'b1;
                    end
                    FN_SLL, FN_SRL: begin
                        d_reg_dst   = 1'b1;
                        d_reg_write = 1'b1;
                        d_alu_src0  = 1'b1;
                    end
                    FN_JR:   d_pc_sel = 1'b1;
                    default: ;
                endcase
            end
            OP_SPEC2: begin
                if (funct == FN_MUL) begin
                    d_reg_dst   = 1'b1;
                    d_reg_write = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                d_reg_write = 1'b1;
                d_alu_src1  = 2'b01;
            end
            OP_LUI: begin
                d_reg_write = 1'b1;
                d_alu_src1  = 2'b11;
            end
            OP_LW, OP_LH, OP_LB: begin
                d_r_en       = 1'b1;
                d_mem_to_reg = 1'b1;
                d_reg_write  = 1'b1;
                d_alu_src1   = 2'b01;
                d_r_width    = (opcode == OP_LW) ? 2'b00 :
                               (opcode == OP_LH) ? 2'b01 : 2'b10;
            end
            OP_SW, OP_SH, OP_SB: begin
                d_w_en     = 1'b1;
                d_alu_src1 = 2'b01;
                d_w_width  = (opcode == OP_SW) ? 2'b00 :
                             (opcode == OP_SH) ? 2'b01 : 2'b10;
            end
            OP_BEQ, OP_BNE: d_branch = 1'b1;
            // Compare-against-zero branches take zero on the ALU B input.
            OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                d_branch   = 1'b1;
                d_alu_src1 = 2'b10;
            end
            OP_J:   d_pc_sel = 1'b1;
            OP_JAL: begin
                d_pc_sel    = 1'b1;
                d_reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset turns the decoded instruction into a bubble; data paths stay live.
    always_comb begin
        PCSel       = d_pc_sel     & ~Reset;
        RegDst      = d_reg_dst    & ~Reset;
        ALUSrc0     = d_alu_src0   & ~Reset;
        ALUSrc1     = d_alu_src1   & {2{~Reset}};
        R_Enable    = d_r_en       & ~Reset;
        W_Enable    = d_w_en       & ~Reset;
        R_Width     = d_r_width    & {2{~Reset}};
        W_Width     = d_w_width    & {2{~Reset}};
        MemToReg    = d_mem_to_reg & ~Reset;
        RegWriteOut = d_reg_write  & ~Reset;
        BranchSel   = d_branch     & ~Reset;
    end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: hand-computed controls, immediates,
// register-file contents, bypass and reset behaviour.
module tb_instruction_decode_stage;

    logic        Clock;
    logic        Reset;
    logic [31:0] Instruction;
    logic [4:0]  rDestSelected;
    logic [31:0] regWriteData;
    logic        RegWrite;
    logic        PCSel, RegDst, ALUSrc0, R_Enable, W_Enable, MemToReg, RegWriteOut, BranchSel;
    logic [1:0]  ALUSrc1, R_Width, W_Width;
    logic [31:0] Reg_Data1, Reg_Data2, Imm32b;

    int n_checks = 0;
    int n_errors = 0;

    instruction_decode_stage dut (
        .Clock(Clock), .Reset(Reset), .Instruction(Instruction),
        .rDestSelected(rDestSelected), .regWriteData(regWriteData), .RegWrite(RegWrite),
        .PCSel(PCSel), .RegDst(RegDst), .ALUSrc0(ALUSrc0), .ALUSrc1(ALUSrc1),
        .R_Enable(R_Enable), .W_Enable(W_Enable), .R_Width(R_Width), .W_Width(W_Width),
        .MemToReg(MemToReg), .RegWriteOut(RegWriteOut), .BranchSel(BranchSel),
        .Reg_Data1(Reg_Data1), .Reg_Data2(Reg_Data2), .Imm32b(Imm32b)
    );

    // ---------------- clock ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Packed view: {PCSel,RegDst,ALUSrc0,ALUSrc1,R_En,W_En,R_W,W_W,MemToReg,RegWrite,Branch}
    logic [31:0] ctrl_obs;
    assign ctrl_obs = {18'd0, PCSel, RegDst, ALUSrc0, ALUSrc1, R_Enable, W_Enable,
                       R_Width, W_Width, MemToReg, RegWriteOut, BranchSel};

    function automatic logic [31:0] ctrl(input logic pc, input logic rd, input logic a0,
                                         input logic [1:0] b1, input logic re, input logic we,
                                         input logic [1:0] rw, input logic [1:0] ww,
                                         input logic m2r, input logic rwo, input logic br);
        return {18'd0, pc, rd, a0, b1, re, we, rw, ww, m2r, rwo, br};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        rDestSelected = addr;
        regWriteData  = data;
        RegWrite      = 1'b1;
        @(posedge Clock);
        #1;
        RegWrite      = 1'b0;
    endtask

    task automatic apply(input logic [31:0] instr);
        Instruction = instr;
        #2;
    endtask

    logic [31:0] c_none, c_rtype, c_shift, c_immop, c_lui, c_lw, c_lh, c_sw, c_sb;
    logic [31:0] c_beq, c_bz, c_j, c_jal;

    initial begin
        c_none  = ctrl(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        c_rtype = ctrl(0, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0);
        c_shift = ctrl(0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0);
        c_immop = ctrl(0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 1, 0);
        c_lui   = ctrl(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0, 1, 0);
        c_lw    = ctrl(0, 0, 0, 2'b01, 1, 0, 2'b00, 2'b00, 1, 1, 0);
        c_lh    = ctrl(0, 0, 0, 2'b01, 1, 0, 2'b01, 2'b00, 1, 1, 0);
        c_sw    = ctrl(0, 0, 0, 2'b01, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        c_sb    = ctrl(0, 0, 0, 2'b01, 0, 1, 2'b00, 2'b10, 0, 0, 0);
        c_beq   = ctrl(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        c_bz    = ctrl(0, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        c_j     = ctrl(1, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        c_jal   = ctrl(1, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0);

        Reset = 1'b1;
        Instruction = 32'h0;
        rDestSelected = 5'd0;
        regWriteData = 32'h0;
        RegWrite = 1'b0;

        // Reset state: registers cleared, controls forced to a bubble.
        @(posedge Clock);
        #1;
        apply(32'h01098020);
        check("reset_rd1", Reg_Data1, 32'h0);
        check("reset_rd2", Reg_Data2, 32'h0);
        check("reset_ctrl", ctrl_obs, c_none);
        check("reset_imm_live", Imm32b, 32'hFFFF8020);
        Reset = 1'b0;
        #1;
        check("add_ctrl_after_reset", ctrl_obs, c_rtype);

        write_reg(5'd8, 32'd5);
        write_reg(5'd9, 32'd7);
        apply(32'h01098020);
        check("add_rd1", Reg_Data1, 32'd5);
        check("add_rd2", Reg_Data2, 32'd7);
        check("add_ctrl", ctrl_obs, c_rtype);

        apply(32'h2151001A);
        check("addi_imm", Imm32b, 32'h0000001A);
        check("addi_ctrl", ctrl_obs, c_immop);
        apply(32'h2108FFFF);
        check("addi_sext", Imm32b, 32'hFFFFFFFF);
        check("addi_rs8", Reg_Data1, 32'd5);
        apply(32'h3108FFFF);
        check("andi_zext", Imm32b, 32'h0000FFFF);
        check("andi_ctrl", ctrl_obs, c_immop);

        apply(32'h72119802);
        check("mul_ctrl", ctrl_obs, c_rtype);
        apply(32'h8D940000);
        check("lw_ctrl", ctrl_obs, c_lw);
        check("lw_imm", Imm32b, 32'h0);
        apply(32'h85940002);
        check("lh_ctrl", ctrl_obs, c_lh);
        apply(32'hAD940004);
        check("sw_ctrl", ctrl_obs, c_sw);
        check("sw_imm", Imm32b, 32'h4);
        apply(32'hA1940001);
        check("sb_ctrl", ctrl_obs, c_sb);

        apply(32'h11090003);
        check("beq_ctrl", ctrl_obs, c_beq);
        apply(32'h19000002);
        check("blez_ctrl", ctrl_obs, c_bz);
        apply(32'h05010004);
        check("bgez_ctrl", ctrl_obs, c_bz);
        apply(32'h08000010);
        check("j_ctrl", ctrl_obs, c_j);
        apply(32'h0C000010);
        check("jal_ctrl", ctrl_obs, c_jal);
        apply(32'h03E00008);
        check("jr_ctrl", ctrl_obs, c_j);
        apply(32'hFC000000);
        check("unknown_op_ctrl", ctrl_obs, c_none);
        apply(32'h0000003F);
        check("unknown_funct_ctrl", ctrl_obs, c_none);
        apply(32'h70000003);
        check("spec2_non_mul_ctrl", ctrl_obs, c_none);

        apply(32'h00084080);
        check("sll_ctrl", ctrl_obs, c_shift);
        apply(32'h3C011234);
        check("lui_ctrl", ctrl_obs, c_lui);
        apply(32'h3C018000);
        check("lui_zext", Imm32b, 32'h00008000);
        apply(32'h34028000);
        check("ori_zext", Imm32b, 32'h00008000);
        apply(32'h24028000);
        check("addiu_sext", Imm32b, 32'hFFFF8000);

        // r0 is hard-wired to zero, even through the bypass.
        write_reg(5'd0, 32'hFFFFFFFF);
        apply(32'h00004020);
        check("r0_after_write", Reg_Data1, 32'h0);
        rDestSelected = 5'd0;
        regWriteData  = 32'h55;
        RegWrite      = 1'b1;
        #2;
        check("r0_no_bypass", Reg_Data2, 32'h0);
        RegWrite = 1'b0;

        // Same-cycle bypass on both ports, then the value is really stored.
        apply(32'h01098020);
        rDestSelected = 5'd8;
        regWriteData  = 32'hAA;
        RegWrite      = 1'b1;
        #1;
        check("bypass_rs", Reg_Data1, 32'hAA);
        check("bypass_other_port", Reg_Data2, 32'd7);
        @(posedge Clock);
        #1;
        RegWrite = 1'b0;
        #1;
        check("bypass_stored", Reg_Data1, 32'hAA);
        rDestSelected = 5'd9;
        regWriteData  = 32'h1234;
        RegWrite      = 1'b1;
        #1;
        check("bypass_rt", Reg_Data2, 32'h1234);
        RegWrite = 1'b0;
        #1;
        check("no_write_no_bypass", Reg_Data2, 32'd7);

        // Reset wins over a write on the same edge.
        Reset = 1'b1;
        write_reg(5'd9, 32'h123);
        Reset = 1'b0;
        #1;
        check("reset_priority_r9", Reg_Data2, 32'h0);
        check("reset_clears_r8", Reg_Data1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
